// File: rtl/tail_light_sequencer_pkg.sv
// Shared mode encodings, side-lamp patterns and LED field offsets for the
// Thunderbird-style tail light sequencer.
package tail_light_sequencer_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE    = 3'd0,
        MODE_RIGHT   = 3'd1,
        MODE_LEFT    = 3'd2,
        MODE_BRAKE   = 3'd3,
        MODE_BRAKE_R = 3'd4,
        MODE_BRAKE_L = 3'd5,
        MODE_HAZARD  = 3'd6
    } mode_t;

    // Side patterns are innermost-lamp-first: bit 2 is the lamp next to centre.
    localparam logic [2:0] PAT_P0 = 3'b100;
    localparam logic [2:0] PAT_P1 = 3'b110;
    localparam logic [2:0] PAT_P2 = 3'b111;
    localparam logic [2:0] PAT_P3 = 3'b000;

    localparam int RIGHT_LSB  = 0;
    localparam int CENTER_LSB = 3;
    localparam int LEFT_LSB   = 7;

    function automatic mode_t decode_mode(input logic [3:0] code);
        mode_t m;
        m = MODE_IDLE;
        if (code[3]) begin
            m = MODE_HAZARD;
        end else begin
            case (code[2:0])
                3'b001:  m = MODE_RIGHT;
                3'b011:  m = MODE_LEFT;
                3'b100:  m = MODE_BRAKE;
                3'b110:  m = MODE_BRAKE;
                3'b101:  m = MODE_BRAKE_R;
                3'b111:  m = MODE_BRAKE_L;
                default: m = MODE_IDLE;
            endcase
        end
        return m;
    endfunction

    // Modes in which step pulses move the phase along.
    function automatic logic is_sequencing(input mode_t m);
        return (m == MODE_RIGHT) || (m == MODE_LEFT) || (m == MODE_BRAKE_R) ||
               (m == MODE_BRAKE_L) || (m == MODE_HAZARD);
    endfunction

endpackage

// File: rtl/tail_light_sequencer_side_pattern.sv
// Maps a sequence phase to the innermost-first 3-lamp side pattern.
module side_pattern
    import tail_light_sequencer_pkg::*;
(
    input  logic [1:0] phase,
    output logic [2:0] pattern
);

    always_comb begin
        pattern = PAT_P3;
        case (phase)
            2'd0:    pattern = PAT_P0;
            2'd1:    pattern = PAT_P1;
            2'd2:    pattern = PAT_P2;
            default: pattern = PAT_P3;
        endcase
    end

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail light sequencer: decodes the lamp-state code into a mode, steps the
// turn/hazard phase on divider pulses and drives the registered LED bank.
module tail_light_sequencer
    import tail_light_sequencer_pkg::*;
#(
    parameter int SIDE_LAMPS   = 3,
    parameter int CENTER_LAMPS = 4,
    parameter int STEP_HOLD    = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                step,
    input  logic [3:0]                          state,
    output logic [2*SIDE_LAMPS+CENTER_LAMPS-1:0] led,
    output logic [1:0]                          phase
);

    localparam int         LED_W     = 2*SIDE_LAMPS + CENTER_LAMPS;
    localparam logic [3:0] HOLD_LAST = 4'(STEP_HOLD - 1);

    mode_t              mode_q, mode_next, mode_new;
    logic [1:0]         phase_q, phase_next;
    logic [3:0]         hold_cnt, hold_next;
    logic [LED_W-1:0]   led_q, led_next;
    logic [2:0]         right_pat, left_raw, left_pat;

    assign mode_new = decode_mode(state);

    // A mode change restarts the sequence and swallows any concurrent step.
    always_comb begin
        mode_next  = mode_q;
        phase_next = phase_q;
        hold_next  = hold_cnt;
        if (mode_new != mode_q) begin
            mode_next  = mode_new;
            phase_next = 2'd0;
            hold_next  = 4'd0;
        end else if (step && is_sequencing(mode_q)) begin
            if (hold_cnt == HOLD_LAST) begin
                hold_next = 4'd0;
                if (mode_q == MODE_HAZARD) begin
                    phase_next = (phase_q == 2'd0) ? 2'd1 : 2'd0;
                end else begin
                    phase_next = phase_q + 2'd1;
                end
            end else begin
                hold_next = hold_cnt + 4'd1;
            end
        end
    end

    side_pattern u_right (
        .phase   (phase_next),
        .pattern (right_pat)
    );

    side_pattern u_left (
        .phase   (phase_next),
        .pattern (left_raw)
    );

    // The left side's innermost lamp sits at its LSB, so the pattern is mirrored.
    assign left_pat = {left_raw[0], left_raw[1], left_raw[2]};

    always_comb begin
        led_next = '0;
        case (mode_next)
            MODE_RIGHT: begin
                led_next[RIGHT_LSB +: 3] = right_pat;
            end
            MODE_LEFT: begin
                led_next[LEFT_LSB +: 3] = left_pat;
            end
            MODE_BRAKE: begin
                led_next = '1;
            end
            MODE_BRAKE_R: begin
                led_next[CENTER_LSB +: CENTER_LAMPS] = {CENTER_LAMPS{1'b1}};
                led_next[LEFT_LSB +: 3]              = 3'b111;
                led_next[RIGHT_LSB +: 3]             = right_pat;
            end
            MODE_BRAKE_L: begin
                led_next[CENTER_LSB +: CENTER_LAMPS] = {CENTER_LAMPS{1'b1}};
                led_next[RIGHT_LSB +: 3]             = 3'b111;
                led_next[LEFT_LSB +: 3]              = left_pat;
            end
            MODE_HAZARD: begin
                led_next[RIGHT_LSB +: 3] = (phase_next == 2'd0) ? 3'b111 : 3'b000;
                led_next[LEFT_LSB +: 3]  = (phase_next == 2'd0) ? 3'b111 : 3'b000;
            end
            default: begin
                led_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_IDLE;
            phase_q  <= 2'd0;
            hold_cnt <= 4'd0;
            led_q    <= '0;
        end else begin
            mode_q   <= mode_next;
            phase_q  <= phase_next;
            hold_cnt <= hold_next;
            led_q    <= led_next;
        end
    end

    assign led   = led_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Self-checking bench for tail_light_sequencer: a vector table on a
// STEP_HOLD=1 instance plus hand-written sequences on a STEP_HOLD=2 instance.
module tb_tail_light_sequencer;

    typedef struct {
        logic       rst;
        logic       step;
        logic [3:0] state;
        logic [9:0] exp_led;
        logic [1:0] exp_phase;
        string      name;
    } vec_t;

    typedef struct {
        bit         sel;
        logic [9:0] exp_led;
        logic [1:0] exp_phase;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_a, step_b;
    logic [3:0] state_a, state_b;
    logic [9:0] led_a, led_b;
    logic [1:0] phase_a, phase_b;

    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    tail_light_sequencer #(.STEP_HOLD(1)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .step  (step_a),
        .state (state_a),
        .led   (led_a),
        .phase (phase_a)
    );

    tail_light_sequencer #(.STEP_HOLD(2)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .step  (step_b),
        .state (state_b),
        .led   (led_b),
        .phase (phase_b)
    );

    task automatic applyStimulus(input bit sel, input logic r, input logic s,
                                 input logic [3:0] st, input logic [9:0] el,
                                 input logic [1:0] ep, input string nm);
        exp_t e;
        rst = r;
        if (sel) begin
            step_b  = s;
            state_b = st;
        end else begin
            step_a  = s;
            state_a = st;
        end
        e.sel       = sel;
        e.exp_led   = el;
        e.exp_phase = ep;
        e.name      = nm;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [9:0] got_led;
        logic [1:0] got_phase;
        checks++;
        if (sb.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e         = sb.pop_front();
        got_led   = e.sel ? led_b : led_a;
        got_phase = e.sel ? phase_b : phase_a;
        if (got_led === e.exp_led && got_phase === e.exp_phase) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: led=%03h phase=%0d, expected led=%03h phase=%0d",
                     e.name, got_led, got_phase, e.exp_led, e.exp_phase);
        end
    endtask

    task automatic runCycle(input bit sel, input logic r, input logic s,
                            input logic [3:0] st, input logic [9:0] el,
                            input logic [1:0] ep, input string nm);
        applyStimulus(sel, r, s, st, el, ep, nm);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst     = 1'b1;
        step_a  = 1'b0;
        step_b  = 1'b0;
        state_a = 4'h0;
        state_b = 4'h0;

        // Reset dominates a live turn code and step
        vecs.push_back('{1'b1, 1'b1, 4'h3, 10'h000, 2'd0, "reset_0"});
        vecs.push_back('{1'b1, 1'b1, 4'h3, 10'h000, 2'd0, "reset_1"});
        vecs.push_back('{1'b0, 1'b0, 4'h0, 10'h000, 2'd0, "idle_after_reset"});
        vecs.push_back('{1'b0, 1'b1, 4'h0, 10'h000, 2'd0, "idle_step_ignored"});
        // Right turn
        vecs.push_back('{1'b0, 1'b0, 4'h1, 10'h004, 2'd0, "right_enter"});
        vecs.push_back('{1'b0, 1'b0, 4'h1, 10'h004, 2'd0, "right_hold"});
        vecs.push_back('{1'b0, 1'b1, 4'h1, 10'h006, 2'd1, "right_step1"});
        vecs.push_back('{1'b0, 1'b0, 4'h1, 10'h006, 2'd1, "right_gap"});
        vecs.push_back('{1'b0, 1'b1, 4'h1, 10'h007, 2'd2, "right_step2"});
        vecs.push_back('{1'b0, 1'b1, 4'h1, 10'h000, 2'd3, "right_step3"});
        vecs.push_back('{1'b0, 1'b0, 4'h1, 10'h000, 2'd3, "right_gap3"});
        vecs.push_back('{1'b0, 1'b1, 4'h1, 10'h004, 2'd0, "right_wrap"});
        vecs.push_back('{1'b0, 1'b1, 4'h1, 10'h006, 2'd1, "right_step5"});
        // Step coincident with a mode change is discarded
        vecs.push_back('{1'b0, 1'b1, 4'h3, 10'h080, 2'd0, "simul_left"});
        vecs.push_back('{1'b0, 1'b1, 4'h3, 10'h180, 2'd1, "left_step1"});
        vecs.push_back('{1'b0, 1'b1, 4'h3, 10'h380, 2'd2, "left_step2"});
        // Mid-sequence reset with step high
        vecs.push_back('{1'b1, 1'b1, 4'h3, 10'h000, 2'd0, "midseq_reset"});
        vecs.push_back('{1'b0, 1'b0, 4'h3, 10'h080, 2'd0, "left_after_reset"});
        // Brake plus left turn
        vecs.push_back('{1'b0, 1'b0, 4'h7, 10'h0FF, 2'd0, "brake_l_enter"});
        vecs.push_back('{1'b0, 1'b1, 4'h7, 10'h1FF, 2'd1, "brake_l_step1"});
        vecs.push_back('{1'b0, 1'b1, 4'h7, 10'h3FF, 2'd2, "brake_l_step2"});
        vecs.push_back('{1'b0, 1'b1, 4'h7, 10'h07F, 2'd3, "brake_l_step3"});
        vecs.push_back('{1'b0, 1'b1, 4'h4, 10'h3FF, 2'd0, "brake_enter"});
        vecs.push_back('{1'b0, 1'b1, 4'h6, 10'h3FF, 2'd0, "brake_alias_step"});
        // Brake plus right turn
        vecs.push_back('{1'b0, 1'b0, 4'h5, 10'h3FC, 2'd0, "brake_r_enter"});
        vecs.push_back('{1'b0, 1'b1, 4'h5, 10'h3FE, 2'd1, "brake_r_step1"});
        // Idle alias toggling
        vecs.push_back('{1'b0, 1'b0, 4'h0, 10'h000, 2'd0, "idle_0000"});
        vecs.push_back('{1'b0, 1'b0, 4'h2, 10'h000, 2'd0, "idle_0010"});
        vecs.push_back('{1'b0, 1'b0, 4'h0, 10'h000, 2'd0, "idle_0000_again"});
        // Hazard with single-pulse hold; alias codes keep the phase
        vecs.push_back('{1'b0, 1'b0, 4'h8, 10'h387, 2'd0, "hazard_enter"});
        vecs.push_back('{1'b0, 1'b1, 4'h8, 10'h000, 2'd1, "hazard_step1"});
        vecs.push_back('{1'b0, 1'b1, 4'h8, 10'h387, 2'd0, "hazard_step2"});
        vecs.push_back('{1'b0, 1'b1, 4'hF, 10'h000, 2'd1, "hazard_alias_step"});

        #3;
        foreach (vecs[i]) begin
            runCycle(1'b0, vecs[i].rst, vecs[i].step, vecs[i].state,
                     vecs[i].exp_led, vecs[i].exp_phase, vecs[i].name);
        end
        step_a = 1'b0;

        // STEP_HOLD=2 instance: hazard needs two pulses per flash phase
        runCycle(1'b1, 1'b0, 1'b0, 4'hA, 10'h387, 2'd0, "b_hazard_enter");
        runCycle(1'b1, 1'b0, 1'b1, 4'hA, 10'h387, 2'd0, "b_hazard_step1");
        runCycle(1'b1, 1'b0, 1'b0, 4'hA, 10'h387, 2'd0, "b_hazard_gap");
        runCycle(1'b1, 1'b0, 1'b1, 4'hA, 10'h000, 2'd1, "b_hazard_step2");
        runCycle(1'b1, 1'b0, 1'b1, 4'hA, 10'h000, 2'd1, "b_hazard_step3");
        runCycle(1'b1, 1'b0, 1'b1, 4'hA, 10'h387, 2'd0, "b_hazard_step4");
        // Leave a half-counted hold, then a mode change must clear it
        runCycle(1'b1, 1'b0, 1'b1, 4'hA, 10'h387, 2'd0, "b_hazard_half");
        runCycle(1'b1, 1'b0, 1'b0, 4'h1, 10'h004, 2'd0, "b_right_enter");
        runCycle(1'b1, 1'b0, 1'b1, 4'h1, 10'h004, 2'd0, "b_right_step1");
        runCycle(1'b1, 1'b0, 1'b1, 4'h1, 10'h006, 2'd1, "b_right_step2");
        runCycle(1'b1, 1'b1, 1'b1, 4'h1, 10'h000, 2'd0, "b_reset");
        step_b = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
